// File: rtl/sweep_pkg.sv
// Shared types and defaults for the sweep peak finder: FSM state encoding,
// default widths and a helper for sizing the skip counter.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    COLLECT = 2'd2,
    REPORT  = 2'd3
  } sweep_pf_state_t;

  localparam int FREQ_W_DEF       = 32;
  localparam int DATA_W_DEF       = 16;
  localparam int CNT_W_DEF        = 16;
  localparam int SKIP_SAMPLES_DEF = 1;
  localparam int MIN_MAG_DEF      = 64;

  // Skip counter must hold SKIP_SAMPLES itself; never narrower than one bit.
  function automatic int skipWidth(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sweep_peak_finder_peak_tracker.sv
// Holds the best (largest-magnitude) sample seen since the last clear,
// together with the tuning word and phase that came with it.
module peak_tracker #(
  parameter int FREQ_W = 32,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [FREQ_W-1:0] i_freq,
  input  logic [DATA_W-1:0] i_phase,
  input  logic [DATA_W-1:0] i_mag,
  output logic [FREQ_W-1:0] o_freq,
  output logic [DATA_W-1:0] o_phase,
  output logic [DATA_W-1:0] o_mag,
  output logic              o_hasSample
);

  logic [FREQ_W-1:0] r_freq;
  logic [DATA_W-1:0] r_phase;
  logic [DATA_W-1:0] r_mag;
  logic              r_hasSample;
  logic              w_update;

  // Strict compare so that equal magnitudes keep the earliest sample.
  assign w_update = i_load && (!r_hasSample || (i_mag > r_mag));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_freq      <= '0;
      r_phase     <= '0;
      r_mag       <= '0;
      r_hasSample <= 1'b0;
    end else if (i_clear) begin
      r_freq      <= '0;
      r_phase     <= '0;
      r_mag       <= '0;
      r_hasSample <= 1'b0;
    end else if (w_update) begin
      r_freq      <= i_freq;
      r_phase     <= i_phase;
      r_mag       <= i_mag;
      r_hasSample <= 1'b1;
    end
  end

  assign o_freq      = r_freq;
  assign o_phase     = r_phase;
  assign o_mag       = r_mag;
  assign o_hasSample = r_hasSample;

endmodule

// File: rtl/sweep_peak_finder.sv
// Tags phase-detector samples with the live tuning word during a sweep and
// reports the maximum-magnitude point once the sweep finishes.
module sweep_peak_finder
  import sweep_pkg::*;
#(
  parameter int FREQ_W       = FREQ_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int SKIP_SAMPLES = SKIP_SAMPLES_DEF,
  parameter int MIN_MAG      = MIN_MAG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sweep_start,
  input  logic              sweep_done,
  input  logic [FREQ_W-1:0] dds_freq,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] phase_in,
  input  logic [DATA_W-1:0] magnitude_in,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [FREQ_W-1:0] peak_freq,
  output logic [DATA_W-1:0] peak_phase,
  output logic [DATA_W-1:0] peak_magnitude,
  output logic [CNT_W-1:0]  sample_count,
  output logic              result_found,
  output logic              result_overrun
);

  localparam int                SKIP_W    = skipWidth(SKIP_SAMPLES);
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP_SAMPLES);
  localparam logic [DATA_W-1:0] MAG_MIN   = DATA_W'(MIN_MAG);
  localparam sweep_pf_state_t   START_ST  = (SKIP_SAMPLES == 0) ? COLLECT : SKIP;

  sweep_pf_state_t   r_state;
  sweep_pf_state_t   w_next;
  logic [SKIP_W-1:0] r_skipCnt;
  logic [CNT_W-1:0]  r_count;
  logic              r_overrun;
  logic              w_accept;
  logic              w_skipDec;
  logic              w_busy;
  logic              w_resultValid;
  logic              w_hasSample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A new start always restarts the sweep, even over a pending result.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (sweep_start) w_next = START_ST;
      end
      SKIP: begin
        if (sweep_start)                           w_next = START_ST;
        else if (sweep_done)                       w_next = REPORT;
        else if (data_valid && (r_skipCnt <= SKIP_W'(1))) w_next = COLLECT;
      end
      COLLECT: begin
        if (sweep_start)     w_next = START_ST;
        else if (sweep_done) w_next = REPORT;
      end
      REPORT: begin
        if (sweep_start)       w_next = START_ST;
        else if (result_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy        = 1'b0;
    w_resultValid = 1'b0;
    w_accept      = 1'b0;
    w_skipDec     = 1'b0;
    unique case (r_state)
      SKIP: begin
        w_busy    = 1'b1;
        w_skipDec = data_valid && !sweep_start;
      end
      COLLECT: begin
        w_busy   = 1'b1;
        w_accept = data_valid && !sweep_start;
      end
      REPORT:  w_resultValid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skipCnt <= '0;
    end else if (sweep_start) begin
      r_skipCnt <= SKIP_LOAD;
    end else if (w_skipDec && (r_skipCnt != '0)) begin
      r_skipCnt <= r_skipCnt - SKIP_W'(1);
    end
  end

  // Saturating so a very long sweep never wraps back to a small count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (sweep_start) begin
      r_count <= '0;
    end else if (w_accept && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= sweep_start && (r_state == REPORT);
    end
  end

  peak_tracker #(
    .FREQ_W (FREQ_W),
    .DATA_W (DATA_W)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (sweep_start),
    .i_load      (w_accept),
    .i_freq      (dds_freq),
    .i_phase     (phase_in),
    .i_mag       (magnitude_in),
    .o_freq      (peak_freq),
    .o_phase     (peak_phase),
    .o_mag       (peak_magnitude),
    .o_hasSample (w_hasSample)
  );

  assign busy           = w_busy;
  assign result_valid   = w_resultValid;
  assign sample_count   = r_count;
  assign result_overrun = r_overrun;
  assign result_found   = w_hasSample && (r_count != '0) && (peak_magnitude >= MAG_MIN);

endmodule

// File: tb/tb_sweep_peak_finder.sv
// Directed bench for sweep_peak_finder: expected reports are queued as each
// sweep ends and a monitor compares them when result_valid rises.
module tb_sweep_peak_finder;

  logic        clk;
  logic        reset;
  logic        sweep_start;
  logic        sweep_done;
  logic [31:0] dds_freq;
  logic        data_valid;
  logic [15:0] phase_in;
  logic [15:0] magnitude_in;
  logic        busy;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] peak_freq;
  logic [15:0] peak_phase;
  logic [15:0] peak_magnitude;
  logic [15:0] sample_count;
  logic        result_found;
  logic        result_overrun;

  typedef struct {
    logic [31:0] freq;
    logic [15:0] phase;
    logic [15:0] mag;
    logic [15:0] count;
    logic        found;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  logic prevValid = 1'b0;

  sweep_peak_finder #(
    .FREQ_W(32), .DATA_W(16), .CNT_W(16), .SKIP_SAMPLES(1), .MIN_MAG(64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sweep_start    (sweep_start),
    .sweep_done     (sweep_done),
    .dds_freq       (dds_freq),
    .data_valid     (data_valid),
    .phase_in       (phase_in),
    .magnitude_in   (magnitude_in),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .peak_freq      (peak_freq),
    .peak_phase     (peak_phase),
    .peak_magnitude (peak_magnitude),
    .sample_count   (sample_count),
    .result_found   (result_found),
    .result_overrun (result_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] f, input logic [15:0] p,
                               input logic [15:0] m, input logic withDone);
    dds_freq     = f;
    phase_in     = p;
    magnitude_in = m;
    data_valid   = 1'b1;
    sweep_done   = withDone;
    waitEdge();
    data_valid   = 1'b0;
    sweep_done   = 1'b0;
  endtask

  task automatic pulseStart();
    sweep_start = 1'b1;
    waitEdge();
    sweep_start = 1'b0;
  endtask

  task automatic pulseDone(input exp_t e);
    sbQ.push_back(e);
    sweep_done = 1'b1;
    waitEdge();
    sweep_done = 1'b0;
    checkOutput("valid_after_done", 64'(result_valid), 64'd1);
  endtask

  task automatic acceptResult();
    result_ready = 1'b1;
    waitEdge();
    result_ready = 1'b0;
    checkOutput("valid_clears_after_ready", 64'(result_valid), 64'd0);
    checkOutput("idle_not_busy", 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor: each new report must match the oldest queued expectation.
  always @(negedge clk) begin
    if (result_valid && !prevValid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_result_valid", 64'(result_valid), 64'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("sb_peak_freq",      64'(peak_freq),      64'(e.freq));
        checkOutput("sb_peak_phase",     64'(peak_phase),     64'(e.phase));
        checkOutput("sb_peak_magnitude", 64'(peak_magnitude), 64'(e.mag));
        checkOutput("sb_sample_count",   64'(sample_count),   64'(e.count));
        checkOutput("sb_result_found",   64'(result_found),   64'(e.found));
      end
    end
    prevValid = result_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    reset        = 1'b1;
    sweep_start  = 1'b0;
    sweep_done   = 1'b0;
    dds_freq     = 32'hDEAD_BEEF;
    data_valid   = 1'b1;
    phase_in     = 16'h1234;
    magnitude_in = 16'h4321;
    result_ready = 1'b0;
    #12;
    checkOutput("reset_busy",         64'(busy),           64'd0);
    checkOutput("reset_result_valid", 64'(result_valid),   64'd0);
    checkOutput("reset_peak_freq",    64'(peak_freq),      64'd0);
    checkOutput("reset_peak_mag",     64'(peak_magnitude), 64'd0);
    checkOutput("reset_sample_count", 64'(sample_count),   64'd0);
    checkOutput("reset_found",        64'(result_found),   64'd0);
    checkOutput("reset_overrun",      64'(result_overrun), 64'd0);
    data_valid = 1'b0;
    waitEdge();
    reset = 1'b0;
    waitEdge();

    // T1: first sample dropped, tie at 200 keeps the earlier one.
    pulseStart();
    checkOutput("t1_busy_after_start", 64'(busy), 64'd1);
    applyStimulus(32'h0100_0000, 16'd0,   16'd10,  1'b0);
    applyStimulus(32'h0100_0010, 16'd100, 16'd200, 1'b0);
    applyStimulus(32'h0100_0020, 16'd200, 16'd150, 1'b0);
    applyStimulus(32'h0100_0030, 16'd300, 16'd200, 1'b0);
    applyStimulus(32'h0100_0040, 16'd400, 16'd90,  1'b0);
    e = '{freq: 32'h0100_0010, phase: 16'd100, mag: 16'd200, count: 16'd4, found: 1'b1};
    pulseDone(e);
    waitEdge();
    acceptResult();

    // T2: every accepted magnitude below the threshold.
    pulseStart();
    applyStimulus(32'h0200_0000, 16'd7000, 16'd40, 1'b0);
    applyStimulus(32'h0200_0001, 16'd7001, 16'd30, 1'b0);
    applyStimulus(32'h0200_0002, 16'd7002, 16'd30, 1'b0);
    applyStimulus(32'h0200_0003, 16'd7003, 16'd30, 1'b0);
    e = '{freq: 32'h0200_0001, phase: 16'd7001, mag: 16'd30, count: 16'd3, found: 1'b0};
    pulseDone(e);
    acceptResult();

    // T3: empty sweep.
    pulseStart();
    e = '{freq: 32'h0, phase: 16'h0, mag: 16'h0, count: 16'h0, found: 1'b0};
    pulseDone(e);
    acceptResult();

    // T4: result held without ready, then overwritten by a new start.
    pulseStart();
    applyStimulus(32'h0300_0000, 16'd0,     16'd5,    1'b0);
    applyStimulus(32'h0300_0100, 16'hFE0C, 16'd1000, 1'b0);
    e = '{freq: 32'h0300_0100, phase: 16'hFE0C, mag: 16'd1000, count: 16'd1, found: 1'b1};
    pulseDone(e);
    for (int i = 0; i < 50; i++) begin
      waitEdge();
      checkOutput("t4_hold_valid", 64'(result_valid),   64'd1);
      checkOutput("t4_hold_freq",  64'(peak_freq),      64'h0300_0100);
      checkOutput("t4_hold_mag",   64'(peak_magnitude), 64'd1000);
    end
    pulseStart();
    checkOutput("t4_overrun_pulse",   64'(result_overrun), 64'd1);
    checkOutput("t4_busy_restart",    64'(busy),           64'd1);
    checkOutput("t4_valid_dropped",   64'(result_valid),   64'd0);
    checkOutput("t4_cleared_count",   64'(sample_count),   64'd0);
    waitEdge();
    checkOutput("t4_overrun_one_cyc", 64'(result_overrun), 64'd0);

    // T5: a sample coinciding with done is still counted.
    applyStimulus(32'h0400_0000, 16'd0,  16'd20,  1'b0);
    applyStimulus(32'h0400_0001, 16'd11, 16'd100, 1'b0);
    e = '{freq: 32'h0400_0002, phase: 16'd22, mag: 16'd500, count: 16'd2, found: 1'b1};
    sbQ.push_back(e);
    applyStimulus(32'h0400_0002, 16'd22, 16'd500, 1'b1);
    checkOutput("t5_valid_after_done", 64'(result_valid), 64'd1);
    acceptResult();

    // Threshold boundary: magnitude exactly MIN_MAG is a valid find.
    pulseStart();
    applyStimulus(32'h0500_0000, 16'd0, 16'd9,  1'b0);
    applyStimulus(32'h0500_0001, 16'd5, 16'd64, 1'b0);
    e = '{freq: 32'h0500_0001, phase: 16'd5, mag: 16'd64, count: 16'd1, found: 1'b1};
    pulseDone(e);
    acceptResult();

    // Start and done together: start wins.
    sweep_start = 1'b1;
    sweep_done  = 1'b1;
    waitEdge();
    sweep_start = 1'b0;
    sweep_done  = 1'b0;
    checkOutput("start_wins_busy",  64'(busy),         64'd1);
    checkOutput("start_wins_valid", 64'(result_valid), 64'd0);

    // T6: reset in the middle of collection.
    applyStimulus(32'h0600_0000, 16'd0, 16'd50,  1'b0);
    applyStimulus(32'h0600_0001, 16'd1, 16'd300, 1'b0);
    applyStimulus(32'h0600_0002, 16'd2, 16'd400, 1'b0);
    checkOutput("t6_count_mid", 64'(sample_count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_reset_busy",  64'(busy),           64'd0);
    checkOutput("t6_reset_count", 64'(sample_count),   64'd0);
    checkOutput("t6_reset_mag",   64'(peak_magnitude), 64'd0);
    checkOutput("t6_reset_freq",  64'(peak_freq),      64'd0);
    waitEdge();
    waitEdge();
    reset = 1'b0;
    sweep_done = 1'b1;
    waitEdge();
    sweep_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      waitEdge();
      checkOutput("t6_no_result", 64'(result_valid), 64'd0);
    end

    checkOutput("scoreboard_drained", 64'(sbQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
